// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller: FSM encodings,
// BCD digit limit and the default timer terminal load.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [3:0]  BCD_MAX    = 4'd9;

    // 1,000,000 cycles per tick: 10 ms at 100 MHz
    localparam logic [19:0] DEFAULT_TL = 20'd999999;

endpackage

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// One BCD digit (0-9) with increment, synchronous clear and carry out.
// Four of these are cascaded through carry_o to form SS.hh.
module bcd_digit
    import stopwatch_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       inc_i,
    input  logic       clr_i,
    output logic [3:0] digit_o,
    output logic       carry_o
);

    // Carry is combinational so the whole cascade settles in one cycle
    assign carry_o = inc_i && (digit_o == BCD_MAX);

    // Digit register: clear has priority, increment wraps 9 -> 0
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of block ordering.
        if (rst_i) begin
            digit_o <= 4'd0;
        end else if (clr_i) begin
            digit_o <= 4'd0;
        end else if (inc_i) begin
            digit_o <= (digit_o == BCD_MAX) ? 4'd0 : digit_o + 4'd1;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: Start/Stop/Clear FSM that drives the 10 ms tick
// timer (enable, reset, terminal load) and a 4-digit BCD time counter
// advanced by each timer_full tick.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter logic [19:0] TL_VALUE = DEFAULT_TL
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_stop_i,
    input  logic        clear_i,
    input  logic        timer_full_i,
    output logic        timer_en_o,
    output logic        timer_rst_o,
    output logic [19:0] tl_o,
    output logic [3:0]  hundredths_o,
    output logic [3:0]  tenths_o,
    output logic [3:0]  sec_ones_o,
    output logic [3:0]  sec_tens_o,
    output logic        running_o,
    output logic        overflow_o
);

    state_t state_q, state_d;
    logic   go_idle;
    logic   tick;
    logic   carry_h, carry_t, carry_o1, carry_wrap;

    assign tl_o = TL_VALUE;

    // Only PAUSE can return to IDLE; this also clears time and overflow
    assign go_idle = (state_q != ST_IDLE) && (state_d == ST_IDLE);

    // Ticks count in RUN and PAUSE; a tick arriving with RUN->PAUSE is real
    assign tick = timer_full_i && (state_q != ST_IDLE);

    // Next-state logic for the Start/Stop/Clear FSM
    always_comb begin
        // NOTE: default assigned first so no path leaves state_d unassigned,
        // which would otherwise infer a latch.
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_stop_i) state_d = ST_RUN;
            ST_RUN:   if (start_stop_i) state_d = ST_PAUSE;
            ST_PAUSE: begin
                // Clear wins over a simultaneous start/stop
                if (clear_i)           state_d = ST_IDLE;
                else if (start_stop_i) state_d = ST_RUN;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // State and timer-control registers, loaded from the next state so the
    // timer enable lines up with the first RUN cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            timer_en_o  <= 1'b0;
            running_o   <= 1'b0;
            timer_rst_o <= 1'b1;
        end else begin
            state_q     <= state_d;
            timer_en_o  <= (state_d == ST_RUN);
            running_o   <= (state_d == ST_RUN);
            timer_rst_o <= go_idle || ((state_q == ST_IDLE) && clear_i);
        end
    end

    // Sticky overflow: set on the 99.99 -> 00.00 wrap, cleared with the time
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_o <= 1'b0;
        end else if (go_idle) begin
            overflow_o <= 1'b0;
        end else if (carry_wrap) begin
            overflow_o <= 1'b1;
        end
    end

    bcd_digit u_hundredths (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (tick),
        .clr_i   (go_idle),
        .digit_o (hundredths_o),
        .carry_o (carry_h)
    );

    bcd_digit u_tenths (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (carry_h),
        .clr_i   (go_idle),
        .digit_o (tenths_o),
        .carry_o (carry_t)
    );

    bcd_digit u_sec_ones (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (carry_t),
        .clr_i   (go_idle),
        .digit_o (sec_ones_o),
        .carry_o (carry_o1)
    );

    bcd_digit u_sec_tens (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (carry_o1),
        .clr_i   (go_idle),
        .digit_o (sec_tens_o),
        .carry_o (carry_wrap)
    );

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed testbench for stopwatch_ctrl with TL_VALUE = 4 (5-cycle ticks).
module tb_stopwatch_ctrl;

    logic        clk_i;
    logic        rst_i;
    logic        start_stop_i;
    logic        clear_i;
    logic        timer_full_i;
    logic        timer_en_o;
    logic        timer_rst_o;
    logic [19:0] tl_o;
    logic [3:0]  hundredths_o;
    logic [3:0]  tenths_o;
    logic [3:0]  sec_ones_o;
    logic [3:0]  sec_tens_o;
    logic        running_o;
    logic        overflow_o;

    int n_cmp;
    int n_err;

    // Time as four BCD nibbles SS.hh, so 00.12 reads as 16'h0012
    logic [15:0] digits;
    assign digits = {sec_tens_o, sec_ones_o, tenths_o, hundredths_o};

    stopwatch_ctrl #(.TL_VALUE(20'd4)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_stop_i (start_stop_i),
        .clear_i      (clear_i),
        .timer_full_i (timer_full_i),
        .timer_en_o   (timer_en_o),
        .timer_rst_o  (timer_rst_o),
        .tl_o         (tl_o),
        .hundredths_o (hundredths_o),
        .tenths_o     (tenths_o),
        .sec_ones_o   (sec_ones_o),
        .sec_tens_o   (sec_tens_o),
        .running_o    (running_o),
        .overflow_o   (overflow_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Advance one clock and settle just after the edge
    task automatic cycle();
        @(posedge clk_i);
        #1;
    endtask

    // Decimal tick count 0..9999 to packed BCD nibbles
    function automatic logic [15:0] to_bcd(input int n);
        logic [3:0] d3, d2, d1, d0;
        d3 = 4'((n / 1000) % 10);
        d2 = 4'((n / 100) % 10);
        d1 = 4'((n / 10) % 10);
        d0 = 4'(n % 10);
        return {d3, d2, d1, d0};
    endfunction

    task automatic test_reset();
        rst_i = 1'b1; start_stop_i = 1'b0; clear_i = 1'b0; timer_full_i = 1'b0;
        repeat (2) cycle();
        n_cmp++; if (timer_rst_o !== 1'b1) begin n_err++; $display("FAIL rst_timer_rst: got %b want 1", timer_rst_o); end
        n_cmp++; if (tl_o !== 20'd4) begin n_err++; $display("FAIL rst_tl: got %0d want 4", tl_o); end
        n_cmp++; if (digits !== 16'h0000) begin n_err++; $display("FAIL rst_digits: got %h want 0000", digits); end
        n_cmp++; if (timer_en_o !== 1'b0 || running_o !== 1'b0 || overflow_o !== 1'b0) begin
            n_err++; $display("FAIL rst_flags: en=%b run=%b ovf=%b want 000", timer_en_o, running_o, overflow_o); end
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        n_cmp++; if (timer_rst_o !== 1'b1) begin n_err++; $display("FAIL rst_hold_until_edge: got %b want 1", timer_rst_o); end
        cycle();
        n_cmp++; if (timer_rst_o !== 1'b0) begin n_err++; $display("FAIL rst_release: got %b want 0", timer_rst_o); end
        n_cmp++; if (timer_en_o !== 1'b0) begin n_err++; $display("FAIL idle_en: got %b want 0", timer_en_o); end
        // Clear accepted in IDLE pulses the timer reset for one cycle
        clear_i = 1'b1; cycle(); clear_i = 1'b0;
        n_cmp++; if (timer_rst_o !== 1'b1) begin n_err++; $display("FAIL idle_clear_pulse: got %b want 1", timer_rst_o); end
        cycle();
        n_cmp++; if (timer_rst_o !== 1'b0) begin n_err++; $display("FAIL idle_clear_end: got %b want 0", timer_rst_o); end
        // Ticks are not counted in IDLE
        timer_full_i = 1'b1; cycle(); timer_full_i = 1'b0; cycle();
        n_cmp++; if (digits !== 16'h0000) begin n_err++; $display("FAIL idle_tick_ignored: got %h want 0000", digits); end
    endtask

    task automatic test_run();
        start_stop_i = 1'b1; cycle(); start_stop_i = 1'b0;
        n_cmp++; if (running_o !== 1'b1 || timer_en_o !== 1'b1) begin
            n_err++; $display("FAIL run_enter: run=%b en=%b want 11", running_o, timer_en_o); end
        for (int k = 1; k <= 12; k++) begin
            repeat (4) cycle();
            timer_full_i = 1'b1;
            n_cmp++; if (digits !== to_bcd(k - 1)) begin
                n_err++; $display("FAIL run_before_tick%0d: got %h want %h", k, digits, to_bcd(k - 1)); end
            cycle();
            timer_full_i = 1'b0;
            n_cmp++; if (digits !== to_bcd(k)) begin
                n_err++; $display("FAIL run_after_tick%0d: got %h want %h", k, digits, to_bcd(k)); end
        end
        n_cmp++; if (digits !== 16'h0012) begin n_err++; $display("FAIL run_total: got %h want 0012", digits); end
        // Clear is ignored while running
        clear_i = 1'b1; cycle(); clear_i = 1'b0;
        n_cmp++; if (digits !== 16'h0012 || running_o !== 1'b1 || timer_rst_o !== 1'b0) begin
            n_err++; $display("FAIL run_clear_ignored: digits=%h run=%b trst=%b want 0012 1 0", digits, running_o, timer_rst_o); end
    endtask

    task automatic test_pause();
        start_stop_i = 1'b1; cycle(); start_stop_i = 1'b0;
        n_cmp++; if (running_o !== 1'b0 || timer_en_o !== 1'b0) begin
            n_err++; $display("FAIL pause_flags: run=%b en=%b want 00", running_o, timer_en_o); end
        repeat (3) cycle();
        n_cmp++; if (digits !== 16'h0012) begin n_err++; $display("FAIL pause_frozen: got %h want 0012", digits); end
    endtask

    task automatic test_pause_clear();
        start_stop_i = 1'b1; clear_i = 1'b1; cycle(); start_stop_i = 1'b0; clear_i = 1'b0;
        n_cmp++; if (digits !== 16'h0000 || overflow_o !== 1'b0) begin
            n_err++; $display("FAIL pclr_digits: digits=%h ovf=%b want 0000 0", digits, overflow_o); end
        n_cmp++; if (running_o !== 1'b0 || timer_rst_o !== 1'b1) begin
            n_err++; $display("FAIL pclr_state: run=%b trst=%b want 0 1", running_o, timer_rst_o); end
        cycle();
        n_cmp++; if (timer_rst_o !== 1'b0) begin n_err++; $display("FAIL pclr_rst_end: got %b want 0", timer_rst_o); end
    endtask

    task automatic test_overflow();
        start_stop_i = 1'b1; cycle(); start_stop_i = 1'b0;
        // Back-to-back ticks every cycle to reach 99.99
        timer_full_i = 1'b1;
        repeat (9999) cycle();
        timer_full_i = 1'b0;
        n_cmp++; if (digits !== 16'h9999 || overflow_o !== 1'b0) begin
            n_err++; $display("FAIL ovf_preload: digits=%h ovf=%b want 9999 0", digits, overflow_o); end
        // Wrapping tick lands in the same cycle as the pause and still counts
        timer_full_i = 1'b1; start_stop_i = 1'b1; cycle(); timer_full_i = 1'b0; start_stop_i = 1'b0;
        n_cmp++; if (digits !== 16'h0000 || overflow_o !== 1'b1 || running_o !== 1'b0) begin
            n_err++; $display("FAIL ovf_wrap: digits=%h ovf=%b run=%b want 0000 1 0", digits, overflow_o, running_o); end
        repeat (2) cycle();
        n_cmp++; if (overflow_o !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", overflow_o); end
        clear_i = 1'b1; cycle(); clear_i = 1'b0;
        n_cmp++; if (overflow_o !== 1'b0 || timer_rst_o !== 1'b1) begin
            n_err++; $display("FAIL ovf_cleared: ovf=%b trst=%b want 0 1", overflow_o, timer_rst_o); end
    endtask

    task automatic test_reset_mid_run();
        cycle();
        start_stop_i = 1'b1; cycle(); start_stop_i = 1'b0;
        timer_full_i = 1'b1;
        repeat (347) cycle();
        timer_full_i = 1'b0;
        n_cmp++; if (digits !== 16'h0347 || running_o !== 1'b1) begin
            n_err++; $display("FAIL mid_preload: digits=%h run=%b want 0347 1", digits, running_o); end
        // Assert reset between edges; outputs must react without a clock
        #2 rst_i = 1'b1;
        #1;
        n_cmp++; if (digits !== 16'h0000) begin n_err++; $display("FAIL mid_async_digits: got %h want 0000", digits); end
        n_cmp++; if (running_o !== 1'b0 || timer_en_o !== 1'b0 || timer_rst_o !== 1'b1) begin
            n_err++; $display("FAIL mid_async_ctrl: run=%b en=%b trst=%b want 0 0 1", running_o, timer_en_o, timer_rst_o); end
        #2 rst_i = 1'b0;
        cycle();
        n_cmp++; if (timer_rst_o !== 1'b0 || running_o !== 1'b0 || digits !== 16'h0000) begin
            n_err++; $display("FAIL mid_after_release: trst=%b run=%b digits=%h want 0 0 0000", timer_rst_o, running_o, digits); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_run();
        test_pause();
        test_pause_clear();
        test_overflow();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
